// File: rtl/shm_paged_dma_rr.sv
// Multi-channel DMA between processor-local memories and a paged shared memory (SHM).
// Requests are granted round-robin. Each transfer walks the SHM page chain through the
// page-list RAM and moves one word every two cycles. Completion is reported by a
// one-cycle ack on the owning channel.
module shm_paged_dma_rr #(
    parameter int unsigned PROC_CNT = 4,
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned LOCAL_AW = 4,
    parameter int unsigned SHM_AW   = 8,
    parameter int unsigned PAGE_AW  = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [PROC_CNT-1:0]                  req,
    input  logic [PROC_CNT-1:0]                  dir,
    input  logic [PROC_CNT*LOCAL_AW-1:0]         loc_start,
    input  logic [PROC_CNT*(LOCAL_AW+1)-1:0]     length,
    input  logic [PROC_CNT*(SHM_AW-PAGE_AW)-1:0] first_pg,
    output logic [PROC_CNT-1:0]                  ack,
    output logic                                 err,
    output logic [PROC_CNT-1:0]                  grant,
    output logic [LOCAL_AW-1:0]                  loc_addr,
    output logic                                 loc_we,
    output logic [WORD_W-1:0]                    loc_wdata,
    input  logic [WORD_W-1:0]                    loc_rdata,
    output logic [SHM_AW-1:0]                    shm_addr,
    output logic                                 shm_we,
    output logic [WORD_W-1:0]                    shm_wdata,
    input  logic [WORD_W-1:0]                    shm_rdata,
    output logic [SHM_AW-PAGE_AW-1:0]            pl_addr,
    input  logic [SHM_AW-PAGE_AW-1:0]            pl_rdata
);

    localparam int unsigned PG_W  = SHM_AW - PAGE_AW;
    localparam int unsigned LEN_W = LOCAL_AW + 1;
    localparam int unsigned IDX_W = (PROC_CNT > 1) ? $clog2(PROC_CNT) : 1;

    typedef enum logic [2:0] {StIdle, StRd, StWr, StLink, StLwait, StAck} state_e;

    state_e              state_q, state_d;
    logic [PROC_CNT-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic                xdir_q, xdir_d;
    logic [LOCAL_AW-1:0] cur_loc_q, cur_loc_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [PG_W-1:0]     page_q, page_d;
    logic [PAGE_AW-1:0]  ofs_q, ofs_d;
    logic                err_q, err_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic                sel_dir;
    logic [LOCAL_AW-1:0] sel_loc;
    logic [LEN_W-1:0]    sel_len;
    logic [PG_W-1:0]     sel_pg;

    // Round-robin scan: first requester at or above rr_q, then wrap to the lowest requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < PROC_CNT; k++) begin
            if (!win_found && req[k] && (IDX_W'(k) >= rr_q)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
        for (int k = 0; k < PROC_CNT; k++) begin
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end

    // Pick the winning channel's descriptor fields.
    always_comb begin
        sel_dir = 1'b0;
        sel_loc = '0;
        sel_len = '0;
        sel_pg  = '0;
        for (int k = 0; k < PROC_CNT; k++) begin
            if (IDX_W'(k) == win_idx) begin
                sel_dir = dir[k];
                sel_loc = loc_start[k*LOCAL_AW +: LOCAL_AW];
                sel_len = length[k*LEN_W +: LEN_W];
                sel_pg  = first_pg[k*PG_W +: PG_W];
            end
        end
    end

    // Next-state logic for the transfer FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        xdir_d    = xdir_q;
        cur_loc_d = cur_loc_q;
        rem_d     = rem_q;
        page_d    = page_q;
        ofs_d     = ofs_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d   = PROC_CNT'(1) << win_idx;
                    rr_d      = (win_idx == IDX_W'(PROC_CNT - 1)) ? '0 : win_idx + 1'b1;
                    xdir_d    = sel_dir;
                    cur_loc_d = sel_loc;
                    rem_d     = sel_len;
                    page_d    = sel_pg;
                    ofs_d     = '0;
                    // Page 0 is the null page: nothing to move, but it is an error if words
                    // were requested.
                    if ((sel_len == '0) || (sel_pg == '0)) begin
                        state_d = StAck;
                        err_d   = (sel_len != '0);
                    end else begin
                        state_d = StRd;
                        err_d   = 1'b0;
                    end
                end
            end
            StRd: state_d = StWr;
            StWr: begin
                rem_d     = rem_q - 1'b1;
                cur_loc_d = cur_loc_q + 1'b1;
                ofs_d     = ofs_q + 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    state_d = StAck;
                end else if (ofs_q == '1) begin
                    state_d = StLink;
                end else begin
                    state_d = StRd;
                end
            end
            StLink: state_d = StLwait;
            StLwait: begin
                page_d = pl_rdata;
                if (pl_rdata == '0) begin
                    err_d   = 1'b1;
                    state_d = StAck;
                end else begin
                    state_d = StRd;
                end
            end
            StAck: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any transfer without an ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_q      <= '0;
            xdir_q    <= 1'b0;
            cur_loc_q <= '0;
            rem_q     <= '0;
            page_q    <= '0;
            ofs_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            xdir_q    <= xdir_d;
            cur_loc_q <= cur_loc_d;
            rem_q     <= rem_d;
            page_q    <= page_d;
            ofs_q     <= ofs_d;
            err_q     <= err_d;
        end
    end

    // Moore output decode. Write data is the source RAM's read port, forwarded in WR because
    // both RAMs return data one cycle after the address is presented in RD.
    always_comb begin
        ack       = '0;
        err       = 1'b0;
        loc_addr  = '0;
        loc_we    = 1'b0;
        loc_wdata = '0;
        shm_addr  = '0;
        shm_we    = 1'b0;
        shm_wdata = '0;
        pl_addr   = '0;
        unique case (state_q)
            StRd: begin
                if (xdir_q) shm_addr = {page_q, ofs_q};
                else        loc_addr = cur_loc_q;
            end
            StWr: begin
                if (xdir_q) begin
                    loc_addr  = cur_loc_q;
                    loc_we    = 1'b1;
                    loc_wdata = shm_rdata;
                end else begin
                    shm_addr  = {page_q, ofs_q};
                    shm_we    = 1'b1;
                    shm_wdata = loc_rdata;
                end
            end
            StLink: pl_addr = page_q;
            StAck: begin
                ack = grant_q;
                err = err_q;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;

endmodule
